// File: rtl/rreg_file_if.sv
// Register-file bus: write-back writes, decode reads,
// and load scoreboard marks.
interface rreg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wite_Rreg;
    logic [ADDR_W-1:0] wite_Rreg_addr;
    logic [DATA_W-1:0] wite_Rreg_data;
    logic              read_Rreg1;
    logic [ADDR_W-1:0] read_Rreg1_addr;
    logic [DATA_W-1:0] read_Rreg1_data;
    logic              read_Rreg2;
    logic [ADDR_W-1:0] read_Rreg2_addr;
    logic [DATA_W-1:0] read_Rreg2_data;
    logic              mark_busy;
    logic [ADDR_W-1:0] mark_busy_addr;
    logic              busy1;
    logic              busy2;

    modport master (
        output wite_Rreg, wite_Rreg_addr, wite_Rreg_data,
        output read_Rreg1, read_Rreg1_addr,
        output read_Rreg2, read_Rreg2_addr,
        output mark_busy, mark_busy_addr,
        input  read_Rreg1_data, read_Rreg2_data,
        input  busy1, busy2
    );

    modport slave (
        input  wite_Rreg, wite_Rreg_addr, wite_Rreg_data,
        input  read_Rreg1, read_Rreg1_addr,
        input  read_Rreg2, read_Rreg2_addr,
        input  mark_busy, mark_busy_addr,
        output read_Rreg1_data, read_Rreg2_data,
        output busy1, busy2
    );
endinterface

// File: rtl/rreg_file.sv
// General-purpose register file with write-to-read bypass
// and a per-register pending-load scoreboard.
module rreg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic        clk,
    input logic        rst,
    rreg_file_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;

    logic              wr_en;
    logic              mk_en;
    logic              hit1;
    logic              hit2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign wr_en = bus.wite_Rreg && (bus.wite_Rreg_addr != '0);
    assign mk_en = bus.mark_busy && (bus.mark_busy_addr != '0);

    assign hit1 = bus.wite_Rreg
               && (bus.wite_Rreg_addr == bus.read_Rreg1_addr);
    assign hit2 = bus.wite_Rreg
               && (bus.wite_Rreg_addr == bus.read_Rreg2_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.wite_Rreg_addr] <= bus.wite_Rreg_data;
        end
    end

    // Set after clear so a new load wins over the retiring one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wr_en) begin
                busy[bus.wite_Rreg_addr] <= 1'b0;
            end
            if (mk_en) begin
                busy[bus.mark_busy_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd1 = '0;
        if (!bus.read_Rreg1 || bus.read_Rreg1_addr == '0) begin
            rd1 = '0;
        end else if (hit1) begin
            rd1 = bus.wite_Rreg_data;
        end else begin
            rd1 = regs[bus.read_Rreg1_addr];
        end
    end

    always_comb begin
        rd2 = '0;
        if (!bus.read_Rreg2 || bus.read_Rreg2_addr == '0) begin
            rd2 = '0;
        end else if (hit2) begin
            rd2 = bus.wite_Rreg_data;
        end else begin
            rd2 = regs[bus.read_Rreg2_addr];
        end
    end

    assign bus.read_Rreg1_data = rd1;
    assign bus.read_Rreg2_data = rd2;

    // busy[0] never sets, so address 0 reads as not busy.
    assign bus.busy1 = bus.read_Rreg1
                    && busy[bus.read_Rreg1_addr] && !hit1;
    assign bus.busy2 = bus.read_Rreg2
                    && busy[bus.read_Rreg2_addr] && !hit2;
endmodule

// File: doc/rreg_file.md
# rreg_file

General-purpose register file for the CPU2 pipeline, the receiving end of the write-back stage's register-write interface (`wite_Rreg`, `wite_Rreg_addr`, `wite_Rreg_data`).

- Holds 2^ADDR_W registers of DATA_W bits.
- Serves two read ports to decode, with same-cycle write-to-read bypass.
- Keeps a per-register pending-load scoreboard so decode can stall on load-use hazards until write-back retires the load.

## Interface
Parameters:
- DATA_W, 32, register width (matches `Rreg_Bus`)
- ADDR_W, 5, register address width (matches `Rreg_AddrBus`); register 0 is hardwired zero

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous and active-high
- wite_Rreg  in  1  write enable from write-back stage
- wite_Rreg_addr  in  ADDR_W  write address
- wite_Rreg_data  in  DATA_W  write data
- read_Rreg1  in  1  read port 1 enable
- read_Rreg1_addr  in  ADDR_W  read port 1 address
- read_Rreg1_data  out  DATA_W  read port 1 data (combinational)
- read_Rreg2  in  1  read port 2 enable
- read_Rreg2_addr  in  ADDR_W  read port 2 address
- read_Rreg2_data  out  DATA_W  read port 2 data (combinational)
- mark_busy  in  1  decode issued a load targeting mark_busy_addr
- mark_busy_addr  in  ADDR_W  destination of the issued load
- busy1  out  1  read port 1 operand pending (load in flight, not yet bypassable)
- busy2  out  1  read port 2 operand pending

## Operation
- Storage:
  - Array regs[0..2^ADDR_W-1].
  - Write: on rising clk, when wite_Rreg=1 and wite_Rreg_addr≠0, regs[wite_Rreg_addr] <= wite_Rreg_data.
  - Writes to address 0 are discarded.
- Read port n, combinational, priority order:
  1. read_Rregn=0 → data 0.
  2. addr=0 → data 0.
  3. wite_Rreg=1 and wite_Rreg_addr=addr → wite_Rreg_data (bypass).
  4. Otherwise → regs[addr].
- Scoreboard: busy[i], one bit per register; busy[0] is always 0.
  - Set on rising clk when mark_busy=1 and mark_busy_addr≠0.
  - Cleared on rising clk when wite_Rreg=1 and wite_Rreg_addr=i.
  - Set and clear on the same address in the same cycle: set wins. The new load is in flight; the older one retires.
- busyn = read_Rregn & busy[addr] & ~(wite_Rreg & wite_Rreg_addr=addr).
  - A register retiring this cycle is not busy, because its data is bypassed.
  - Port disabled or addr=0 → busyn=0.
- The two read ports are independent. Identical addresses on both ports return identical data and busy values.

## Timing
- Reset (asserted asynchronously, held any duration):
  - All regs = 0 and all busy = 0 immediately.
  - Read outputs follow the combinational rules, so they read 0 unless bypassed.
  - Writes and marks during reset are ignored.
  - Reset mid-operation discards pending scoreboard bits; no stale busy survives reset release.
- Write latency: data visible on the read port in the same cycle via bypass, and from the array starting the cycle after the edge.
- Scoreboard latency: mark at edge k → busy visible in cycle k+1. Clear at edge m (WB write) → busyn already 0 during cycle m (bypass term), bit cleared from cycle m+1.
- No handshake. wite_Rreg is a single-cycle strobe; every asserted cycle performs one write.
- Back-to-back writes to the same address: the last edge wins; the bypass always reflects the current-cycle input.

## Test plan
- Reset then read: rst=1, then release; read_Rreg1 addr 5, read_Rreg2 addr 31 → both data 0, busy1=busy2=0.
- Write/readback: write addr 3 = 0xDEADBEEF; the same cycle read1 addr 3 → 0xDEADBEEF (bypass); next cycle still 0xDEADBEEF from the array; read2 addr 4 → 0.
- Register 0: write addr 0 = 0xFFFFFFFF → read addr 0 returns 0 both in the same cycle and afterwards; mark_busy addr 0 → busy stays 0.
- Load-use hazard:
  - mark_busy addr 7 at edge k → busy1 (read addr 7) = 1 in cycles k+1..m-1.
  - WB write addr 7 = 0x12345678 in cycle m → busy1=0 and data 0x12345678 in cycle m; busy1=0 at m+1.
- Simultaneous mark and clear on addr 9: busy[9] set earlier; in the same cycle wite_Rreg addr 9 plus mark_busy addr 9 → next cycle busy=1; a second WB write to 9 clears it.
- Async reset mid-operation:
  - busy[10]=1 and regs[10]=0xA5A5A5A5.
  - Assert rst between clock edges → read addr 10 returns 0 and busy=0 before the next edge.
  - A write strobe on the next edge while rst is held leaves regs[10]=0.
